// File: rtl/uart_tx_fifo_reader_pkg.sv
// uart_pkg: shared UART types and defaults
// used by both the transmitter and the receiver
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_par(
    input logic [7:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_reader_if.sv
// uart_tx_fifo_reader_if: FIFO read-side bundle
// master = the reader popping words, slave = the FIFO
interface uart_tx_fifo_reader_if #(
  parameter int DBIT = 8
);

  logic            fifo_rd;
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_r_data;

  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_r_data
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_r_data
  );

endinterface

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: drains the TX FIFO onto the
// serial line, 16x oversampled, LSB first
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int DBIT      = DBIT_DEF,
  parameter int SB_TICK   = SB_TICK_DEF,
  parameter int PARITY_EN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tick,
  uart_tx_fifo_reader_if.master fifo,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam logic [4:0] OS_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

  state_t          state;
  logic [4:0]      s;
  logic [2:0]      n;
  logic [DBIT-1:0] b;
  logic            p;
  logic            pop;

  // pop is Mealy so a waiting byte leaves on the
  // first idle cycle; reset suppresses it
  assign pop = (state == IDLE)
             && !fifo.fifo_empty
             && !rst;

  assign fifo.fifo_rd = pop;
  assign tx_busy      = (state != IDLE);

  // frame sequencer; tx is registered from the
  // current state so the line never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      p            <= 1'b0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            b     <= fifo.fifo_r_data;
            p     <= ^fifo.fifo_r_data;
            s     <= '0;
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (s_tick) begin
            if (s == OS_LAST) begin
              s     <= '0;
              n     <= '0;
              state <= DATA;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        DATA: begin
          tx <= b[0];
          if (s_tick) begin
            if (s == OS_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) begin
                state <= (PARITY_EN != 0)
                       ? PARITY : STOP;
              end else begin
                n <= n + 3'd1;
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        PARITY: begin
          tx <= p;
          if (s_tick) begin
            if (s == OS_LAST) begin
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (s_tick) begin
            if (s == SB_LAST) begin
              s            <= '0;
              tx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
